// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared types and constants for the shift-and-add multiplier
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - accumulator, A shift register, B register and adder
module shift_add_datapath #(
  parameter int TOP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic [TOP_WIDTH-1:0]   i_a,
  input  logic [TOP_WIDTH-1:0]   i_b,
  output logic [2*TOP_WIDTH:0]   o_acc
);

  logic [2*TOP_WIDTH:0]  r_acc;
  logic [TOP_WIDTH-1:0]  r_a;
  logic [TOP_WIDTH-1:0]  r_b;
  logic [TOP_WIDTH:0]    w_sum;
  logic [TOP_WIDTH:0]    w_upper;
  logic [2*TOP_WIDTH:0]  w_acc_step;

  // The upper half is always below 2^TOP_WIDTH after a shift, so the
  // TOP_WIDTH+1 bit sum never loses its carry.
  assign w_sum      = r_acc[2*TOP_WIDTH:TOP_WIDTH] + {1'b0, r_b};
  assign w_upper    = r_a[0] ? w_sum : r_acc[2*TOP_WIDTH:TOP_WIDTH];
  assign w_acc_step = {1'b0, w_upper, r_acc[TOP_WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_a   <= i_a;
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= w_acc_step;
      r_a   <= {1'b0, r_a[TOP_WIDTH-1:1]};
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned multiplier with start/done handshake
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int TOP_WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TOP_WIDTH-1:0]   multiplier,
  input  logic [TOP_WIDTH-1:0]   multiplicand,
  input  logic                   start,
  output logic [2*TOP_WIDTH:0]   product,
  output logic                   done
);

  localparam int CNT_W = cnt_width(TOP_WIDTH);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*TOP_WIDTH:0] r_product;
  logic                 r_done;
  logic                 w_load;
  logic                 w_step;
  logic                 w_finish;
  logic [2*TOP_WIDTH:0] w_acc;

  shift_add_datapath #(
    .TOP_WIDTH (TOP_WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (multiplier),
    .i_b    (multiplicand),
    .o_acc  (w_acc)
  );

  // CALC lasts TOP_WIDTH stepping cycles plus one cycle that registers the
  // settled accumulator, giving the TOP_WIDTH+1 edge start-to-done latency.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(TOP_WIDTH)) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_finish) begin
        r_product <= w_acc;
        r_done    <= 1'b1;
      end else if (w_load) begin
        r_done <= 1'b0;
      end
    end
  end

  assign product = r_product;
  assign done    = r_done;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2*W:0]  product;
  logic          done;

  int            checks = 0;
  int            errors = 0;
  logic [2*W:0]  exp_q[$];
  logic [2*W:0]  last_exp;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .TOP_WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplier   (a),
    .multiplicand (b),
    .start        (start),
    .product      (product),
    .done         (done)
  );

  task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit push);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    if (push) exp_q.push_back((2*W+1)'(ta) * (2*W+1)'(tb_v));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  task automatic wait_result(input string tag, input int inject_at);
    int lat;
    logic [2*W:0] exp;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == inject_at) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, (2*W+1)'(lat), (2*W+1)'(17));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 33'd1, 33'd0);
      exp = 'x;
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_product"}, product, exp);
    end
    last_exp = exp;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("reset_product", product, '0);
    check("reset_done", {32'd0, done}, 33'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_done", {32'd0, done}, 33'd0);

    do_start(16'h96E3, 16'h36F2, 1'b1);
    wait_result("op_96e3", 0);
    check("op_96e3_const", product, 33'h0_2062_8496);
    repeat (6) @(posedge clk);
    #1;
    check("hold_product", product, last_exp);
    check("hold_done", {32'd0, done}, 33'd1);

    do_start(16'hFFFF, 16'hFFFF, 1'b1);
    check("b2b_done_fall", {32'd0, done}, 33'd0);
    wait_result("op_ffff", 0);
    check("op_ffff_msb", {32'd0, product[2*W]}, 33'd0);

    do_start(16'h0000, 16'h1234, 1'b1);
    wait_result("op_zero", 0);

    do_start(16'h0001, 16'hABCD, 1'b1);
    wait_result("op_one", 0);

    do_start(16'd3, 16'd5, 1'b1);
    check("b2b_done_fall2", {32'd0, done}, 33'd0);
    check("b2b_product_held", product, 33'h0ABCD);
    wait_result("op_3x5_inject", 5);
    repeat (3) @(posedge clk);
    #1;
    check("post_inject_product", product, 33'd15);

    do_start(16'h96E3, 16'h36F2, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_product", product, '0);
    check("abort_done", {32'd0, done}, 33'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", {32'd0, done}, 33'd0);
    check("abort_product_idle", product, '0);

    do_start(16'h1234, 16'h0010, 1'b1);
    wait_result("op_after_abort", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
